// File: rtl/midi_pkg.sv
// Shared MIDI definitions: event types, parser states and status nibbles.
package midi_pkg;

    localparam logic [1:0] EVT_NOTE_OFF    = 2'd0;
    localparam logic [1:0] EVT_NOTE_ON     = 2'd1;
    localparam logic [1:0] EVT_CTRL_CHANGE = 2'd2;

    localparam logic [1:0] ST_NO_STATUS = 2'd0;
    localparam logic [1:0] ST_WAIT_D1   = 2'd1;
    localparam logic [1:0] ST_WAIT_D2   = 2'd2;

    localparam logic [3:0] SN_NONE       = 4'h0;
    localparam logic [3:0] SN_NOTE_OFF   = 4'h8;
    localparam logic [3:0] SN_NOTE_ON    = 4'h9;
    localparam logic [3:0] SN_POLY_AT    = 4'hA;
    localparam logic [3:0] SN_CTRL_CHG   = 4'hB;
    localparam logic [3:0] SN_PROG_CHG   = 4'hC;
    localparam logic [3:0] SN_CHAN_AT    = 4'hD;
    localparam logic [3:0] SN_PITCH_BEND = 4'hE;

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic has_two_data(input logic [3:0] nib);
        return (nib != SN_PROG_CHG) && (nib != SN_CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_ctrl.sv
// MIDI byte-stream parser: turns channel voice messages from uart_rx into
// registered note/controller events with a one-slot output and sticky overflow.
module midi_ctrl
    import midi_pkg::*;
#(
    parameter int         OMNI    = 1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_type,
    output logic [3:0] evt_chan,
    output logic [6:0] evt_d1,
    output logic [6:0] evt_d2,
    output logic       overflow
);

    logic [1:0] state;
    logic [3:0] run_stat;
    logic [3:0] run_chan;
    logic [6:0] d1_q;

    logic       is_sys, is_stat, is_data, complete;
    logic       ev_ok, chan_ok, new_evt;
    logic [1:0] ev_type;

    // 0xF8-0xFF (real-time) match none of these and so leave everything alone.
    assign is_sys   = rx_valid && (rx_data[7:3] == 5'b11110);
    assign is_stat  = rx_valid && rx_data[7] && (rx_data[7:4] != 4'hF);
    assign is_data  = rx_valid && !rx_data[7];
    assign complete = is_data && (state == ST_WAIT_D2);

    always_comb begin
        ev_ok   = 1'b0;
        ev_type = EVT_NOTE_OFF;
        case (run_stat)
            SN_NOTE_OFF: ev_ok = 1'b1;
            SN_NOTE_ON: begin
                ev_ok   = 1'b1;
                ev_type = (rx_data[6:0] != 7'd0) ? EVT_NOTE_ON : EVT_NOTE_OFF;
            end
            SN_CTRL_CHG: begin
                ev_ok   = 1'b1;
                ev_type = EVT_CTRL_CHANGE;
            end
            default: ev_ok = 1'b0;
        endcase
    end

    assign chan_ok = (OMNI != 0) || (run_chan == CHANNEL);
    assign new_evt = complete && ev_ok && chan_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_NO_STATUS;
            run_stat <= SN_NONE;
            run_chan <= 4'd0;
            d1_q     <= 7'd0;
        end else if (is_sys) begin
            state    <= ST_NO_STATUS;
            run_stat <= SN_NONE;
            run_chan <= 4'd0;
        end else if (is_stat) begin
            state    <= ST_WAIT_D1;
            run_stat <= rx_data[7:4];
            run_chan <= rx_data[3:0];
        end else if (is_data) begin
            case (state)
                ST_WAIT_D1: begin
                    if (has_two_data(run_stat)) begin
                        d1_q  <= rx_data[6:0];
                        state <= ST_WAIT_D2;
                    end
                end
                ST_WAIT_D2: state <= ST_WAIT_D1;
                default:    state <= ST_NO_STATUS;
            endcase
        end
    end

    // Single output slot: a completing event replaces one being handed off
    // this cycle, but is dropped (and flagged) if the slot is still stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_type  <= EVT_NOTE_OFF;
            evt_chan  <= 4'd0;
            evt_d1    <= 7'd0;
            evt_d2    <= 7'd0;
            overflow  <= 1'b0;
        end else if (new_evt) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_type  <= ev_type;
                evt_chan  <= run_chan;
                evt_d1    <= d1_q;
                evt_d2    <= rx_data[6:0];
            end else begin
                overflow  <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: doc/midi_ctrl.md
MIDI_CTRL -- requirements
Module: midi_ctrl

Interface
REQ-001 Parameter OMNI, default 1, 1 = accept all channels, 0 = accept only CHANNEL.
REQ-002 Parameter CHANNEL, default 0, 4-bit MIDI channel accepted when OMNI=0.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-007 evt_valid  output  1  decoded event available.
REQ-008 evt_ready  input  1  consumer accepts event when evt_valid=1 and evt_ready=1.
REQ-009 evt_type  output  2  0=NOTE_OFF, 1=NOTE_ON, 2=CTRL_CHANGE; 3 never issued.
REQ-010 evt_chan  output  4  channel of the event.
REQ-011 evt_d1  output  7  note number or controller number.
REQ-012 evt_d2  output  7  velocity or controller value.
REQ-013 overflow  output  1  sticky: an event was dropped because the output slot was occupied.

Function
REQ-014 Parser states: NO_STATUS, WAIT_D1, WAIT_D2; at most one transition per rx_valid strobe; no transition when rx_valid=0.
REQ-015 Status byte 0x80-0xEF: latch status nibble and channel (running status), go to WAIT_D1.
REQ-016 Status 0xC0-0xDF (one data byte): WAIT_D1 data byte returns to WAIT_D1, no event.
REQ-017 Status 0x80, 0x90, 0xA0, 0xB0, 0xE0 (two data bytes): WAIT_D1 data byte latches d1, goes to WAIT_D2; WAIT_D2 data byte completes message, returns to WAIT_D1 (running status retained).
REQ-018 Completed 0x8n -> NOTE_OFF; 0x9n with d2!=0 -> NOTE_ON; 0x9n with d2=0 -> NOTE_OFF; 0xBn -> CTRL_CHANGE; 0xAn and 0xEn -> no event.
REQ-019 Completed message on a channel rejected by OMNI/CHANNEL produces no event and does not set overflow.
REQ-020 Real-time bytes 0xF8-0xFF ignored entirely: state, running status and latched d1 unchanged.
REQ-021 System common bytes 0xF0-0xF7 clear running status, go to NO_STATUS.
REQ-022 Data byte (bit7=0) in NO_STATUS ignored.
REQ-023 Status byte arriving in WAIT_D2 abandons partial message, starts the new one per REQ-015/021.
REQ-024 Event output registered: evt_valid and fields update on the clock edge after the rx_valid cycle carrying the completing byte (latency 1).
REQ-025 evt_valid and all evt_* fields held stable until handshake; evt_valid drops the cycle after handshake unless REQ-026 applies.
REQ-026 New event completing in the same cycle as a handshake loads new fields; evt_valid stays 1.
REQ-027 New event completing while evt_valid=1 and evt_ready=0: new event dropped, held event unchanged, overflow set to 1 next cycle.
REQ-028 overflow cleared only by rst.

Reset
REQ-029 On rst=1 at a clock edge: state=NO_STATUS, running status cleared, d1 latch=0, evt_valid=0, evt_type=0, evt_chan=0, evt_d1=0, evt_d2=0, overflow=0.
REQ-030 rst overrides rx_valid and evt_ready in the same cycle; partial message or pending event discarded.
REQ-031 Ports and behaviour are fully defined from the first cycle after rst deasserts.

Structure
REQ-032 Shared package midi_pkg holds event-type constants (NOTE_OFF, NOTE_ON, CTRL_CHANGE), parser-state encoding and status-nibble constants (0x8-0xE).
REQ-033 Single module, no sub-modules; instantiated downstream of uart_rx with rx_valid/rx_data wired to data_valid/data.

Verification
REQ-034 Bytes 0x90,0x3C,0x64, evt_ready=1 -> one evt_valid pulse: type=NOTE_ON, chan=0, d1=0x3C, d2=0x64, one cycle after third strobe.
REQ-035 Running status 0x91,0x40,0x50,0x40,0x00 -> NOTE_ON chan=1 d1=0x40 d2=0x50, then NOTE_OFF chan=1 d1=0x40 d2=0x00.
REQ-036 0xB2,0xF8,0x07,0xF8,0x7F -> one CTRL_CHANGE chan=2 d1=0x07 d2=0x7F; real-time bytes have no effect.
REQ-037 evt_ready=0, send 0x90,0x3C,0x64 then 0x80,0x3C,0x00 -> first event held unchanged, overflow=1; assert rst -> all outputs 0.
REQ-038 OMNI=0, CHANNEL=3: 0x94,0x3C,0x64 -> no event; 0x93,0x3C,0x64 -> NOTE_ON chan=3.
REQ-039 0x90,0x3C,0xF0,0x64 and 0x90,0x3C,0x80,0x3C,0x10 -> first: no event; second: single NOTE_OFF d1=0x3C d2=0x10.
